wav_writer: RTL
===============

# wav_writer

Byte-stream WAV encoder: the transmit-side counterpart of the WAV sample reader. It accepts stereo sample pairs in the 24-bit offset-binary format the reader produces (midscale 32768). It emits a complete 44-byte RIFF/WAVE PCM header, followed by interleaved 16-bit signed little-endian sample data. Output goes on a byte-wide valid/ready interface feeding a file sink, UART or FIFO.

## Interface
- SAMPLE_RATE, 48000, sample rate written to the header (Hz)
- NUM_SAMPLES, 1024, stereo frames per file; sets the header data size

- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a file; ignored unless idle
- in_L  in  24  left sample, offset binary; only [15:0] used
- in_R  in  24  right sample, offset binary; only [15:0] used
- in_valid  in  1  sample pair present
- in_ready  out  1  block accepts a pair this cycle
- byte_out  out  8  output byte
- byte_valid  out  1  byte_out is valid
- byte_ready  in  1  sink accepts byte_out
- busy  out  1  file in progress
- done  out  1  one-cycle pulse after the final byte is accepted

## Operation
- **States:** IDLE, HEADER, WAIT_SAMPLE, DATA, DONE.
- **IDLE → HEADER:** on start. The header byte index resets to 0 and the frame counter clears.
- **HEADER:** emits bytes 0..43 in order, little endian:
  - "RIFF", 36+4·NUM_SAMPLES (32 bit), "WAVE", "fmt ", 16 (32 bit)
  - 1 (16 bit), 2 (16 bit), SAMPLE_RATE (32 bit), 4·SAMPLE_RATE (32 bit)
  - 4 (16 bit), 16 (16 bit), "data", 4·NUM_SAMPLES (32 bit)
- **After byte 43 is accepted:**
  - NUM_SAMPLES = 0 → DONE.
  - Otherwise → WAIT_SAMPLE.
- **WAIT_SAMPLE:** in_ready = 1. On in_valid && in_ready, both channels are captured and the state moves to DATA.
- **DATA:** emits 4 bytes in order: L[7:0], L[15:8], R[7:0], R[15:8].
  - Conversion: sample = in[15:0] ^ 16'h8000, equivalent to subtracting 32768 mod 2^16.
  - Bits [23:16] are ignored.
  - After the 4th byte is accepted, the frame counter increments. If the counter reaches NUM_SAMPLES → DONE, else → WAIT_SAMPLE.
- **DONE:** lasts one cycle with done = 1, then → IDLE.
- **busy:** 1 in HEADER, WAIT_SAMPLE and DATA; 0 in IDLE and DONE.
- **start:** ignored in every state except IDLE.
- **Internal widths:** frame counter 32 bit; header size fields computed at elaboration, with 32-bit wrap.

## Timing
- **Reset values:** byte_valid 0, byte_out 0, in_ready 0, busy 0, done 0; state IDLE.
- **Reset mid-operation:** takes effect on the next edge from any state. A pending byte and any captured sample are discarded, and no done pulse is issued.
- **Start latency:** start sampled in IDLE at edge t → at t+1, byte_valid = 1, byte_out = 0x52 ('R'), busy = 1.
- **Byte handshake:**
  - Transfer occurs on byte_valid && byte_ready at a rising edge.
  - While byte_valid && !byte_ready, byte_out holds stable.
  - byte_valid never drops without a transfer, except on reset.
- **Throughput:** with byte_ready held high, bytes transfer on consecutive cycles. The 44-byte header completes in 44 cycles.
- **Header to first sample:** last header byte accepted at edge t → in_ready = 1 from t+1.
- **Sample capture:** pair captured at edge t → in_ready = 0 and byte_valid = 1 with the L low byte at t+1. in_ready is never high while byte_valid is high.
- **Frame rate:** minimum 5 cycles per frame (1 capture + 4 bytes).
- **End of file:** final byte accepted at edge t → done = 1 and busy = 0 during cycle t+1; IDLE at t+2. A start at t+2 is accepted.

## Test plan
- **Header, default parameters:** start, byte_ready = 1 → 44 consecutive bytes.
  - Bytes 4–7 = 24 10 00 00.
  - Bytes 24–27 = 80 BB 00 00.
  - Bytes 28–31 = 00 EE 02 00.
  - Bytes 40–43 = 00 10 00 00.
- **Conversion:** frames (L, R) = (0x000000, 0x008000), then (0x00FFFF, 0x123456) → bytes 00 80 00 00, then FF 7F 56 B4.
- **Backpressure:** byte_ready toggled pseudo-randomly and held low for 7 cycles mid-header and mid-data → byte_out stable while stalled; byte sequence identical to the no-stall run.
- **Full file, NUM_SAMPLES = 3:**
  - Exactly 56 bytes transferred.
  - done pulses once, one cycle after the last transfer.
  - in_ready is never high while byte_valid = 1.
  - A start issued while busy is ignored.
- **Empty file, NUM_SAMPLES = 0:** header only, bytes 40–43 = 00 00 00 00, then done; in_ready never asserts.
- **Reset mid-data:** rst at byte 2 of frame 1 → next cycle all outputs at reset values. A fresh start then reproduces the header from 0x52.

Source files
------------

// File: rtl/wav_writer_if.sv
// rtl/wav_writer_if.sv - sample input, byte output and control signals of the WAV encoder
interface wav_writer_if;
  logic        start;
  logic [23:0] in_L;
  logic [23:0] in_R;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        done;

  modport master (
    output start, in_L, in_R, in_valid, byte_ready,
    input  in_ready, byte_out, byte_valid, busy, done
  );

  modport slave (
    input  start, in_L, in_R, in_valid, byte_ready,
    output in_ready, byte_out, byte_valid, busy, done
  );
endinterface

// File: rtl/wav_writer.sv
// rtl/wav_writer.sv - streams a 44-byte RIFF/WAVE PCM header then 16-bit stereo frames as bytes
module wav_writer #(
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter int unsigned NUM_SAMPLES = 1024
) (
  input logic         clk,
  input logic         rst,
  wav_writer_if.slave bus
);

  localparam logic [31:0] DATA_SIZE = 32'(4 * NUM_SAMPLES);
  localparam logic [31:0] RIFF_SIZE = 32'(36 + 4 * NUM_SAMPLES);
  localparam logic [31:0] RATE      = 32'(SAMPLE_RATE);
  localparam logic [31:0] BYTE_RATE = 32'(4 * SAMPLE_RATE);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    WAIT_SAMPLE,
    DATA,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  hdr_idx;
  logic [1:0]  byte_idx;
  logic [31:0] frame_cnt;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic [7:0]  hdr_byte;
  logic [7:0]  data_byte;
  logic        last_frame;
  logic        unused_bits;

  // Only the low 16 bits of each offset-binary sample carry PCM data.
  assign unused_bits = ^{bus.in_L[23:16], bus.in_R[23:16]};
  assign last_frame  = (frame_cnt + 32'd1) == NUM_SAMPLES;

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      6'd0:  hdr_byte = 8'h52;
      6'd1:  hdr_byte = 8'h49;
      6'd2:  hdr_byte = 8'h46;
      6'd3:  hdr_byte = 8'h46;
      6'd4:  hdr_byte = RIFF_SIZE[7:0];
      6'd5:  hdr_byte = RIFF_SIZE[15:8];
      6'd6:  hdr_byte = RIFF_SIZE[23:16];
      6'd7:  hdr_byte = RIFF_SIZE[31:24];
      6'd8:  hdr_byte = 8'h57;
      6'd9:  hdr_byte = 8'h41;
      6'd10: hdr_byte = 8'h56;
      6'd11: hdr_byte = 8'h45;
      6'd12: hdr_byte = 8'h66;
      6'd13: hdr_byte = 8'h6D;
      6'd14: hdr_byte = 8'h74;
      6'd15: hdr_byte = 8'h20;
      6'd16: hdr_byte = 8'd16;
      6'd20: hdr_byte = 8'd1;
      6'd22: hdr_byte = 8'd2;
      6'd24: hdr_byte = RATE[7:0];
      6'd25: hdr_byte = RATE[15:8];
      6'd26: hdr_byte = RATE[23:16];
      6'd27: hdr_byte = RATE[31:24];
      6'd28: hdr_byte = BYTE_RATE[7:0];
      6'd29: hdr_byte = BYTE_RATE[15:8];
      6'd30: hdr_byte = BYTE_RATE[23:16];
      6'd31: hdr_byte = BYTE_RATE[31:24];
      6'd32: hdr_byte = 8'd4;
      6'd34: hdr_byte = 8'd16;
      6'd36: hdr_byte = 8'h64;
      6'd37: hdr_byte = 8'h61;
      6'd38: hdr_byte = 8'h74;
      6'd39: hdr_byte = 8'h61;
      6'd40: hdr_byte = DATA_SIZE[7:0];
      6'd41: hdr_byte = DATA_SIZE[15:8];
      6'd42: hdr_byte = DATA_SIZE[23:16];
      6'd43: hdr_byte = DATA_SIZE[31:24];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    data_byte = 8'h00;
    case (byte_idx)
      2'd0: data_byte = sample_l[7:0];
      2'd1: data_byte = sample_l[15:8];
      2'd2: data_byte = sample_r[7:0];
      2'd3: data_byte = sample_r[15:8];
      default: data_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    bus.in_ready   = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_out   = 8'h00;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = HEADER;
      end
      HEADER: begin
        bus.byte_valid = 1'b1;
        bus.byte_out   = hdr_byte;
        bus.busy       = 1'b1;
        if (bus.byte_ready && hdr_idx == 6'd43) begin
          state_next = (NUM_SAMPLES == 0) ? DONE : WAIT_SAMPLE;
        end
      end
      WAIT_SAMPLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (bus.in_valid) state_next = DATA;
      end
      DATA: begin
        bus.byte_valid = 1'b1;
        bus.byte_out   = data_byte;
        bus.busy       = 1'b1;
        if (bus.byte_ready && byte_idx == 2'd3) begin
          state_next = last_frame ? DONE : WAIT_SAMPLE;
        end
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte indices advance only on an accepted transfer, so byte_out holds during stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_idx   <= 6'd0;
      byte_idx  <= 2'd0;
      frame_cnt <= 32'd0;
      sample_l  <= 16'h0000;
      sample_r  <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            hdr_idx   <= 6'd0;
            frame_cnt <= 32'd0;
          end
        end
        HEADER: begin
          if (bus.byte_ready) hdr_idx <= hdr_idx + 6'd1;
        end
        WAIT_SAMPLE: begin
          if (bus.in_valid) begin
            sample_l <= bus.in_L[15:0] ^ 16'h8000;
            sample_r <= bus.in_R[15:0] ^ 16'h8000;
            byte_idx <= 2'd0;
          end
        end
        DATA: begin
          if (bus.byte_ready) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) frame_cnt <= frame_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
